// File: rtl/nvram_upload.sv
// nvram_upload: HPS upload responder streaming a byte-wide core RAM out as 16-bit LE words.
// Optional running checksum returned at address SIZE, enabled by NVRAM_UPLOAD_CKSUM_EN.
module nvram_upload #(
    parameter logic [7:0] INDEX    = 8'd4,
    parameter int         AW       = 10,
    parameter int         SIZE     = 1024,
    parameter int         RAM_LAT  = 1,
    parameter int         PAUSE_TO = 4096
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [26:0]   ioctl_addr,
    output logic [15:0]   ioctl_din,
    output logic          ioctl_wait,
    output logic          pause_req,
    input  logic          pause_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_q,
    output logic          busy
);

    localparam int          TW      = (PAUSE_TO > 1) ? $clog2(PAUSE_TO) : 1;
    localparam logic [TW-1:0] PT_LAST = TW'(PAUSE_TO - 1);
    localparam logic [26:0] SIZE_A  = 27'(SIZE);
    localparam logic [1:0]  LAT_LO  = 2'(RAM_LAT);
    localparam logic [1:0]  LAT_HI  = 2'(RAM_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        READY,
        RD_LO,
        WAIT_LO,
        RD_HI,
        WAIT_HI
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   pause_cnt_q, pause_cnt_d;
    logic [1:0]      lat_cnt_q, lat_cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      lo_q, lo_d;
    logic [15:0]     din_q, din_d;
    logic            wait_q, wait_d;
    logic            pause_req_q, pause_req_d;
    logic            mem_rd_q, mem_rd_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            pend_q, pend_d;
    logic [26:0]     pend_addr_q, pend_addr_d;
`ifdef NVRAM_UPLOAD_CKSUM_EN
    logic [15:0]     sum_q, sum_d;
`endif

    logic            sel;
    logic            req_valid;
    logic [26:0]     req_addr;

    assign sel = ioctl_upload && (ioctl_index == INDEX);

    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        lo_d        = lo_q;
        din_d       = din_q;
        wait_d      = wait_q;
        pause_req_d = pause_req_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
`ifdef NVRAM_UPLOAD_CKSUM_EN
        sum_d       = sum_q;
`endif
        req_valid   = 1'b0;
        req_addr    = ioctl_addr;

        if (!sel) begin
            state_d     = IDLE;
            pause_req_d = 1'b0;
            wait_d      = 1'b0;
            pend_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = PAUSE;
                    pause_req_d = 1'b1;
                    pause_cnt_d = '0;
                    pend_d      = 1'b0;
                    wait_d      = 1'b0;
`ifdef NVRAM_UPLOAD_CKSUM_EN
                    sum_d       = '0;
`endif
                end
                PAUSE: begin
                    pause_cnt_d = pause_cnt_q + TW'(1);
                    // Single-entry queue; an in-range request stalls the host right away.
                    if (ioctl_rd && !wait_q) begin
                        pend_d      = 1'b1;
                        pend_addr_d = ioctl_addr;
                        wait_d      = (ioctl_addr < SIZE_A);
                    end
                    if (pause_ack || (pause_cnt_q == PT_LAST)) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    if (ioctl_rd && !wait_q) begin
                        req_valid = 1'b1;
                        req_addr  = ioctl_addr;
                    end else if (pend_q) begin
                        req_valid = 1'b1;
                        req_addr  = pend_addr_q;
                    end
                    pend_d = 1'b0;
                    if (req_valid) begin
                        addr_d = req_addr[AW-1:0];
                        if (req_addr < SIZE_A) begin
                            wait_d  = 1'b1;
                            state_d = RD_LO;
`ifdef NVRAM_UPLOAD_CKSUM_EN
                        end else if (req_addr == SIZE_A) begin
                            din_d = sum_q;
`endif
                        end else begin
                            din_d = '1;
                        end
                    end
                end
                RD_LO: begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_q;
                    lat_cnt_d  = '0;
                    state_d    = WAIT_LO;
                end
                WAIT_LO: begin
                    // Low strobe leaves the flop one cycle after RD_LO, so wait RAM_LAT+1
                    // cycles; the high strobe is launched on the capture edge itself.
                    lat_cnt_d = lat_cnt_q + 2'd1;
                    if (lat_cnt_q == LAT_LO) begin
                        lo_d       = mem_q;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr_q + AW'(1);
                        state_d    = RD_HI;
                    end
                end
                RD_HI: begin
                    lat_cnt_d = '0;
                    state_d   = WAIT_HI;
                end
                WAIT_HI: begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                    if (lat_cnt_q == LAT_HI) begin
                        din_d   = {mem_q, lo_q};
                        wait_d  = 1'b0;
                        state_d = READY;
`ifdef NVRAM_UPLOAD_CKSUM_EN
                        sum_d   = sum_q + {8'h00, lo_q} + {8'h00, mem_q};
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pause_cnt_q <= '0;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            lo_q        <= '0;
            din_q       <= '0;
            wait_q      <= 1'b0;
            pause_req_q <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
`ifdef NVRAM_UPLOAD_CKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            lo_q        <= lo_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            pause_req_q <= pause_req_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
`ifdef NVRAM_UPLOAD_CKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign pause_req  = pause_req_q;
    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_nvram_upload.sv
// Bench for nvram_upload: expected words queued at request time and compared when ioctl_wait drops.
`timescale 1ns/1ps
module tb_nvram_upload;

    localparam int         AW       = 10;
    localparam int         SIZE     = 1024;
    localparam int         PAUSE_TO = 16;
    localparam logic [7:0] IDX      = 8'd4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          ioctl_upload;
    logic [7:0]    ioctl_index;
    logic          ioctl_rd;
    logic [26:0]   ioctl_addr;
    logic [15:0]   ioctl_din;
    logic          ioctl_wait;
    logic          pause_req;
    logic          pause_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_q;
    logic          busy;

    logic          ack_en;
    logic [7:0]    ram [SIZE];
    logic [7:0]    mem_q_r;
    int unsigned   cyc = 0;
    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [15:0]   exp_q [$];
    logic [AW-1:0] rd_log [$];
    int unsigned   rd_cyc [$];
    logic [15:0]   sum_model;

    always #5 clk = ~clk;

    assign pause_ack = pause_req & ack_en;
    assign mem_q     = mem_q_r;

    // Synchronous RAM model, one cycle from strobe to data.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_q_r <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_log.push_back(mem_addr);
            rd_cyc.push_back(cyc);
        end
    end

    nvram_upload #(
        .INDEX(IDX),
        .AW(AW),
        .SIZE(SIZE),
        .RAM_LAT(1),
        .PAUSE_TO(PAUSE_TO)
    ) dut (
        .clk_sys(clk),
        .reset_n(reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait),
        .pause_req(pause_req),
        .pause_ack(pause_ack),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_q(mem_q),
        .busy(busy)
    );

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic begin_session(input logic ack);
        ack_en       = ack;
        ioctl_index  = IDX;
        ioctl_upload = 1'b1;
        sum_model    = '0;
        tick(3);
    endtask

    task automatic end_session;
        ioctl_upload = 1'b0;
        ioctl_rd     = 1'b0;
        tick(2);
    endtask

    // In-range word read; optionally fires a second ioctl_rd while stalled, which must be ignored.
    task automatic do_read(input logic [26:0] a, input logic dup);
        int          idx;
        int unsigned hi;
        int unsigned base;
        logic [15:0] expw;
        logic [15:0] got;
        idx  = int'(a[AW-1:0]);
        exp_q.push_back({ram[idx+1], ram[idx]});
        sum_model = sum_model + {8'h00, ram[idx]} + {8'h00, ram[idx+1]};
        base = rd_log.size();
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        hi = 0;
        while (ioctl_wait && hi < 40) begin
            hi++;
            if (dup && hi == 2) begin
                ioctl_addr = a ^ 27'h40;
                ioctl_rd   = 1'b1;
            end else begin
                ioctl_rd = 1'b0;
            end
            tick(1);
        end
        ioctl_rd = 1'b0;
        checks++;
        if (hi !== 5) begin
            errors++;
            $display("FAIL wait_len@%h: got %0d cycles expected 5", a, hi);
        end
        got  = ioctl_din;
        expw = exp_q.pop_front();
        checks++;
        if (got !== expw) begin
            errors++;
            $display("FAIL word@%h: got %h expected %h", a, got, expw);
        end
        checks++;
        if (rd_log.size() != base + 2) begin
            errors++;
            $display("FAIL strobes@%h: got %0d expected 2", a, rd_log.size() - base);
        end else if (rd_log[base] !== a[AW-1:0] || rd_log[base+1] !== a[AW-1:0] + AW'(1)) begin
            errors++;
            $display("FAIL strobe_addr@%h: got %h,%h expected %h,%h", a, rd_log[base],
                     rd_log[base+1], a[AW-1:0], a[AW-1:0] + AW'(1));
        end
    endtask

    task automatic oor_read(input logic [26:0] a, input logic [15:0] expv);
        int unsigned base;
        logic        seen_wait;
        logic [15:0] expw;
        exp_q.push_back(expv);
        base = rd_log.size();
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd  = 1'b0;
        seen_wait = ioctl_wait;
        expw = exp_q.pop_front();
        checks++;
        if (ioctl_din !== expw) begin
            errors++;
            $display("FAIL oor_word@%h: got %h expected %h", a, ioctl_din, expw);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1);
            seen_wait = seen_wait | ioctl_wait;
        end
        checks++;
        if (seen_wait !== 1'b0) begin
            errors++;
            $display("FAIL oor_wait@%h: got %b expected 0", a, seen_wait);
        end
        checks++;
        if (rd_log.size() != base) begin
            errors++;
            $display("FAIL oor_strobes@%h: got %0d expected 0", a, rd_log.size() - base);
        end
    endtask

    task automatic test_reset;
        int unsigned n;
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        tick(2);
        checks++;
        if (ioctl_din !== 16'h0000 || ioctl_wait !== 1'b0 || pause_req !== 1'b0 ||
            mem_rd !== 1'b0 || mem_addr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got din=%h wait=%b preq=%b rd=%b addr=%h busy=%b expected all 0",
                     ioctl_din, ioctl_wait, pause_req, mem_rd, mem_addr, busy);
        end
        reset_n = 1'b1;
        tick(1);

        begin_session(1'b1);
        checks++;
        if (busy !== 1'b1 || pause_req !== 1'b1) begin
            errors++;
            $display("FAIL session_start: got busy=%b preq=%b expected 1 1", busy, pause_req);
        end
        ioctl_addr = 27'h40;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(1);
        checks++;
        if (ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL midfetch_wait: got %b expected 1", ioctl_wait);
        end
        reset_n = 1'b0;
        tick(1);
        checks++;
        if (ioctl_wait !== 1'b0 || pause_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midfetch: got wait=%b preq=%b busy=%b expected 0 0 0",
                     ioctl_wait, pause_req, busy);
        end
        n = rd_log.size();
        tick(3);
        ioctl_upload = 1'b0;
        reset_n      = 1'b1;
        tick(4);
        checks++;
        if (rd_log.size() != n) begin
            errors++;
            $display("FAIL reset_no_strobe: got %0d extra expected 0", rd_log.size() - n);
        end

        ioctl_index  = 8'd5;
        ioctl_upload = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || pause_req !== 1'b0) begin
            errors++;
            $display("FAIL wrong_index: got busy=%b preq=%b expected 0 0", busy, pause_req);
        end
        end_session();
    endtask

    task automatic test_basic_word;
        logic [26:0] a;
        begin_session(1'b1);
        ram[10'h10] = 8'h34;
        ram[10'h11] = 8'h12;
        do_read(27'h10, 1'b0);
        checks++;
        if (ioctl_din !== 16'h1234) begin
            errors++;
            $display("FAIL basic_1234: got %h expected 1234", ioctl_din);
        end
        do_read(27'h000, 1'b0);
        do_read(27'(SIZE - 2), 1'b0);
        do_read(27'h2AA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a = 27'($urandom_range(0, SIZE / 2 - 1) * 2);
            do_read(a, 1'b0);
        end
        end_session();
    endtask

    task automatic test_back_to_back;
        begin_session(1'b1);
        do_read(27'h100, 1'b1);
        do_read(27'h102, 1'b0);
        do_read(27'h104, 1'b1);
        end_session();
    endtask

    task automatic test_pause_timeout;
        int unsigned start;
        int unsigned base;
        int unsigned hi;
        int unsigned off;
        logic [15:0] expw;
        ack_en       = 1'b0;
        ioctl_index  = IDX;
        ioctl_upload = 1'b1;
        tick(1);
        start = cyc;
        base  = rd_log.size();
        exp_q.push_back({ram[10'h21], ram[10'h20]});
        ioctl_addr = 27'h20;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        checks++;
        if (ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL queued_wait: got %b expected 1", ioctl_wait);
        end
        hi = 0;
        while (ioctl_wait && hi < 60) begin
            hi++;
            tick(1);
        end
        expw = exp_q.pop_front();
        checks++;
        if (ioctl_wait !== 1'b0 || ioctl_din !== expw) begin
            errors++;
            $display("FAIL queued_word: got %h wait=%b expected %h wait=0", ioctl_din, ioctl_wait, expw);
        end
        checks++;
        if (rd_log.size() != base + 2) begin
            errors++;
            $display("FAIL queued_strobes: got %0d expected 2", rd_log.size() - base);
        end else begin
            off = rd_cyc[base] - start;
            if (off < 16 || off > 18) begin
                errors++;
                $display("FAIL pause_timeout: got first strobe %0d cycles after start expected 16..18", off);
            end
        end
        tick(3);
        checks++;
        if (pause_req !== 1'b1) begin
            errors++;
            $display("FAIL preq_hold: got %b expected 1", pause_req);
        end
        ioctl_upload = 1'b0;
        tick(1);
        checks++;
        if (pause_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL preq_drop: got preq=%b busy=%b expected 0 0", pause_req, busy);
        end
        tick(1);
    endtask

    task automatic test_out_of_range;
        logic [15:0] at_size;
        begin_session(1'b1);
        do_read(27'h12, 1'b0);
        do_read(27'h12, 1'b0);
`ifdef NVRAM_UPLOAD_CKSUM_EN
        at_size = sum_model;
`else
        at_size = 16'hFFFF;
`endif
        oor_read(27'h400, at_size);
        do_read(27'h14, 1'b0);
        oor_read(27'h1000400, 16'hFFFF);
        do_read(27'h16, 1'b0);
        oor_read(27'h402, 16'hFFFF);
        end_session();
    endtask

    task automatic test_abort;
        logic [15:0] prev;
        begin_session(1'b1);
        ram[10'h60] = ~ram[10'h50];
        ram[10'h61] = ~ram[10'h51];
        do_read(27'h50, 1'b0);
        prev = {ram[10'h51], ram[10'h50]};
        ioctl_addr = 27'h60;
        ioctl_rd   = 1'b1;
        tick(1);
        ioctl_rd = 1'b0;
        tick(4);
        checks++;
        if (ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre_wait: got %b expected 1", ioctl_wait);
        end
        ioctl_upload = 1'b0;
        tick(1);
        checks++;
        if (ioctl_din !== prev || ioctl_wait !== 1'b0 || pause_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: got din=%h wait=%b preq=%b busy=%b expected din=%h 0 0 0",
                     ioctl_din, ioctl_wait, pause_req, busy, prev);
        end
        tick(2);
        ioctl_upload = 1'b1;
        tick(1);
        checks++;
        if (pause_req !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: got preq=%b busy=%b expected 1 1", pause_req, busy);
        end
        end_session();
    endtask

`ifdef NVRAM_UPLOAD_CKSUM_EN
    task automatic test_checksum;
        begin_session(1'b1);
        ram[0] = 8'h01;
        ram[1] = 8'h02;
        ram[2] = 8'h03;
        ram[3] = 8'hFF;
        do_read(27'h0, 1'b0);
        do_read(27'h2, 1'b0);
        oor_read(27'h400, 16'h0105);
        do_read(27'h0, 1'b0);
        oor_read(27'h400, 16'h0108);
        end_session();
    endtask
`endif

    initial begin
        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        ack_en       = 1'b0;
        mem_q_r      = '0;
        sum_model    = '0;
        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom_range(0, 255));

        test_reset();
        test_basic_word();
        test_back_to_back();
        test_pause_timeout();
        test_out_of_range();
        test_abort();
`ifdef NVRAM_UPLOAD_CKSUM_EN
        test_checksum();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
